// File: rtl/writeback_unit.sv
// writeback_unit: MEM/WB stage that aligns load data and drives the register bank write port.
module writeback_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [4:0]        in_rd,
    input  logic              in_reg_write,
    input  logic [1:0]        in_wb_sel,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [XLEN-1:0]   in_mem_rdata,
    input  logic [XLEN-1:0]   in_pc_plus4,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [2:0]        in_funct3,
    input  logic              stall,
    input  logic              flush,
    output logic [4:0]        rd,
    output logic              RegWrite,
    output logic [XLEN-1:0]   C,
    output logic              wb_valid,
    output logic              load_fault,
    output logic [CNT_W-1:0]  instret
);
    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;
    localparam logic [2:0] F3_LB    = 3'b000;
    localparam logic [2:0] F3_LH    = 3'b001;
    localparam logic [2:0] F3_LW    = 3'b010;
    localparam logic [2:0] F3_LBU   = 3'b100;
    localparam logic [2:0] F3_LHU   = 3'b101;
    logic             valid_q, valid_d;
    logic [4:0]       rd_q;
    logic             reg_write_q;
    logic [1:0]       wb_sel_q;
    logic [XLEN-1:0]  alu_q, mem_q, pc4_q, imm_q;
    logic [2:0]       f3_q;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             capture;
    logic [1:0]       off;
    logic [7:0]       ld_b;
    logic [15:0]      ld_h;
    logic [XLEN-1:0]  ld_val, src;
    logic             bad_load, fault;
    always_comb begin
        capture   = flush || !stall;
        valid_d   = flush ? 1'b0 : in_valid;
        instret_d = instret_q + CNT_W'(valid_q && !fault && !stall);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            wb_sel_q    <= '0;
            alu_q       <= '0;
            mem_q       <= '0;
            pc4_q       <= '0;
            imm_q       <= '0;
            f3_q        <= '0;
            instret_q   <= '0;
        end else begin
            instret_q <= instret_d;
            if (capture) begin
                valid_q     <= valid_d;
                rd_q        <= in_rd;
                reg_write_q <= in_reg_write;
                wb_sel_q    <= in_wb_sel;
                alu_q       <= in_alu_result;
                mem_q       <= in_mem_rdata;
                pc4_q       <= in_pc_plus4;
                imm_q       <= in_imm;
                f3_q        <= in_funct3;
            end
        end
    end
    // Memory returns a word-aligned word; the address low bits pick the lane.
    always_comb begin
        off      = alu_q[1:0];
        ld_b     = mem_q[{off, 3'b000} +: 8];
        ld_h     = off[1] ? mem_q[31:16] : mem_q[15:0];
        ld_val   = f3_q == F3_LB  ? {{(XLEN-8){ld_b[7]}}, ld_b} :
                   f3_q == F3_LBU ? {{(XLEN-8){1'b0}}, ld_b} :
                   f3_q == F3_LH  ? {{(XLEN-16){ld_h[15]}}, ld_h} :
                   f3_q == F3_LHU ? {{(XLEN-16){1'b0}}, ld_h} : mem_q;
        bad_load = (f3_q == 3'b011) || (f3_q == 3'b110) || (f3_q == 3'b111) ||
                   ((f3_q == F3_LH || f3_q == F3_LHU) && off[0]) ||
                   (f3_q == F3_LW && off != 2'b00);
        fault    = valid_q && wb_sel_q == SEL_LOAD && bad_load;
        src      = wb_sel_q == SEL_ALU  ? alu_q :
                   wb_sel_q == SEL_LOAD ? ld_val :
                   wb_sel_q == SEL_LINK ? pc4_q : imm_q;
        C          = (!valid_q || fault) ? '0 : src;
        rd         = valid_q ? rd_q : 5'd0;
        RegWrite   = valid_q && reg_write_q && rd_q != 5'd0 && !fault;
        wb_valid   = valid_q;
        load_fault = fault;
        instret    = instret_q;
    end
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: scenario tasks plus randomized traffic checked against a behavioural model.
module tb_writeback_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, in_reg_write, stall, flush;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_result, in_mem_rdata, in_pc_plus4, in_imm;
    logic [2:0]  in_funct3;
    logic [4:0]  rd;
    logic        RegWrite, wb_valid, load_fault;
    logic [31:0] C;
    logic [63:0] instret;
    int checks = 0;
    int passed = 0;
    logic        m_valid, m_rw;
    logic [4:0]  m_rd;
    logic [1:0]  m_sel;
    logic [31:0] m_alu, m_mem, m_pc4, m_imm;
    logic [2:0]  m_f3;
    logic [63:0] exp_instret;

    writeback_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_rd(in_rd), .in_reg_write(in_reg_write),
        .in_wb_sel(in_wb_sel), .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
        .in_pc_plus4(in_pc_plus4), .in_imm(in_imm), .in_funct3(in_funct3), .stall(stall),
        .flush(flush), .rd(rd), .RegWrite(RegWrite), .C(C), .wb_valid(wb_valid),
        .load_fault(load_fault), .instret(instret)
    );

    always #5 clk = ~clk;

    function automatic logic exp_fault();
        int o;
        logic ok;
        o = int'(m_alu % 4);
        case (m_f3)
            3'd0, 3'd4: ok = 1'b1;
            3'd1, 3'd5: ok = (o % 2) == 0;
            3'd2:       ok = o == 0;
            default:    ok = 1'b0;
        endcase
        return m_valid && m_sel == 2'd1 && !ok;
    endfunction

    function automatic logic [31:0] exp_load();
        logic [31:0] b, h;
        b = (m_mem >> (8 * (m_alu % 4))) & 32'hFF;
        h = (m_mem >> (8 * (m_alu % 4))) & 32'hFFFF;
        case (m_f3)
            3'd0:    return b >= 128 ? b - 256 : b;
            3'd4:    return b;
            3'd1:    return h >= 32768 ? h - 65536 : h;
            3'd5:    return h;
            default: return m_mem;
        endcase
    endfunction

    function automatic logic [31:0] exp_c();
        if (!m_valid || exp_fault()) return 32'd0;
        case (m_sel)
            2'd0:    return m_alu;
            2'd1:    return exp_load();
            2'd2:    return m_pc4;
            default: return m_imm;
        endcase
    endfunction

    function automatic logic exp_we();
        return m_valid && m_rw && m_rd != 0 && !exp_fault();
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_rd = 0; m_sel = 0;
        m_alu = 0; m_mem = 0; m_pc4 = 0; m_imm = 0; m_f3 = 0;
        exp_instret = 0;
    endtask

    task automatic drv(input logic v, input logic [4:0] r, input logic w, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] m, input logic [31:0] p,
                       input logic [31:0] i, input logic [2:0] f);
        in_valid = v; in_rd = r; in_reg_write = w; in_wb_sel = s;
        in_alu_result = a; in_mem_rdata = m; in_pc_plus4 = p; in_imm = i; in_funct3 = f;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        stall = 0;
        flush = 0;
    endtask

    task automatic tick();
        if (!rst) begin
            if (m_valid && !exp_fault() && !stall) exp_instret = exp_instret + 1;
            if (flush) m_valid = 0;
            else if (!stall) begin
                m_valid = in_valid; m_rd = in_rd; m_rw = in_reg_write; m_sel = in_wb_sel;
                m_alu = in_alu_result; m_mem = in_mem_rdata; m_pc4 = in_pc_plus4;
                m_imm = in_imm; m_f3 = in_funct3;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({RegWrite, C, instret, wb_valid, load_fault, rd} !== {1'b0, 32'd0, 64'd0, 1'b0, 1'b0, 5'd0})
                $display("FAIL reset cycle %0d: got we=%b C=%h instret=%0d valid=%b fault=%b rd=%0d expected all zero",
                         k, RegWrite, C, instret, wb_valid, load_fault, rd);
            else passed++;
        end
    endtask

    task automatic test_alu();
        drv(1, 5, 1, 2'b00, 32'h1234_5678, 0, 0, 0, 0);
        tick();
        idle();
        checks++;
        if ({RegWrite, rd, C, instret} !== {1'b1, 5'd5, 32'h1234_5678, 64'd0})
            $display("FAIL alu: got we=%b rd=%0d C=%h instret=%0d expected we=1 rd=5 C=12345678 instret=0",
                     RegWrite, rd, C, instret);
        else passed++;
        tick();
        checks++;
        if (instret !== 64'd1 || instret !== exp_instret)
            $display("FAIL alu retire: got instret=%0d expected 1", instret);
        else passed++;
    endtask

    task automatic test_loads();
        logic [2:0]  f3s [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
        logic [31:0] offs[5] = '{32'h1002, 32'h1003, 32'h1002, 32'h1000, 32'h1000};
        logic [31:0] exps[5] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
        for (int k = 0; k < 5; k++) begin
            drv(1, 3, 1, 2'b01, offs[k], 32'h80FF_7F01, 0, 0, f3s[k]);
            tick();
            checks++;
            if (C !== exps[k] || C !== exp_c() || RegWrite !== 1'b1 || load_fault !== 1'b0)
                $display("FAIL load f3=%0d off=%0d: got C=%h we=%b fault=%b expected C=%h we=1 fault=0",
                         f3s[k], offs[k][1:0], C, RegWrite, load_fault, exps[k]);
            else passed++;
        end
        idle();
        tick();
        checks++;
        if (instret !== exp_instret)
            $display("FAIL load retire: got instret=%0d expected %0d", instret, exp_instret);
        else passed++;
    endtask

    task automatic test_fault();
        logic [63:0] base;
        base = exp_instret;
        drv(1, 7, 1, 2'b01, 32'h2002, 32'hDEAD_BEEF, 0, 0, 3'b010);
        tick();
        checks++;
        if ({load_fault, RegWrite, C} !== {1'b1, 1'b0, 32'd0})
            $display("FAIL fault lw off2: got fault=%b we=%b C=%h expected fault=1 we=0 C=0", load_fault, RegWrite, C);
        else passed++;
        drv(1, 7, 1, 2'b01, 32'h2000, 32'hDEAD_BEEF, 0, 0, 3'b011);
        tick();
        checks++;
        if ({load_fault, RegWrite, C, instret} !== {1'b1, 1'b0, 32'd0, base})
            $display("FAIL fault f3=011: got fault=%b we=%b C=%h instret=%0d expected fault=1 we=0 C=0 instret=%0d",
                     load_fault, RegWrite, C, instret, base);
        else passed++;
        idle();
        tick();
        checks++;
        if (instret !== base || load_fault !== 1'b0)
            $display("FAIL fault retire: got instret=%0d fault=%b expected instret=%0d fault=0", instret, load_fault, base);
        else passed++;
    endtask

    task automatic test_rd0();
        logic [63:0] base;
        base = exp_instret;
        drv(1, 0, 1, 2'b10, 0, 0, 32'h104, 0, 0);
        tick();
        idle();
        checks++;
        if ({RegWrite, rd, C} !== {1'b0, 5'd0, 32'h104})
            $display("FAIL rd0: got we=%b rd=%0d C=%h expected we=0 rd=0 C=00000104", RegWrite, rd, C);
        else passed++;
        tick();
        checks++;
        if (instret !== base + 1)
            $display("FAIL rd0 retire: got instret=%0d expected %0d", instret, base + 1);
        else passed++;
    endtask

    task automatic test_stall_flush();
        logic [63:0] base;
        drv(1, 9, 1, 2'b00, 32'hCAFE_0001, 0, 0, 0, 0);
        tick();
        base = exp_instret;
        idle();
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({RegWrite, rd, C, instret} !== {1'b1, 5'd9, 32'hCAFE_0001, base})
                $display("FAIL stall cycle %0d: got we=%b rd=%0d C=%h instret=%0d expected we=1 rd=9 C=cafe0001 instret=%0d",
                         k, RegWrite, rd, C, instret, base);
            else passed++;
        end
        stall = 0;
        tick();
        checks++;
        if (instret !== base + 1 || wb_valid !== 1'b0)
            $display("FAIL stall release: got instret=%0d valid=%b expected instret=%0d valid=0", instret, wb_valid, base + 1);
        else passed++;
        drv(1, 4, 1, 2'b11, 0, 0, 0, 32'hABCD_E000, 0);
        tick();
        base = exp_instret;
        stall = 1;
        flush = 1;
        tick();
        checks++;
        if ({wb_valid, RegWrite, C, instret} !== {1'b0, 1'b0, 32'd0, base})
            $display("FAIL flush while stalled: got valid=%b we=%b C=%h instret=%0d expected valid=0 we=0 C=0 instret=%0d",
                     wb_valid, RegWrite, C, instret, base);
        else passed++;
        drv(1, 4, 1, 2'b11, 0, 0, 0, 32'h1111_1000, 0);
        stall = 0;
        flush = 0;
        tick();
        flush = 1;
        tick();
        checks++;
        if (wb_valid !== 1'b0 || instret !== base + 1)
            $display("FAIL flush retires held: got valid=%b instret=%0d expected valid=0 instret=%0d", wb_valid, instret, base + 1);
        else passed++;
        idle();
    endtask

    task automatic test_async_reset();
        drv(1, 12, 1, 2'b00, 32'h5555_AAAA, 0, 0, 0, 0);
        tick();
        tick();
        #2;
        rst = 1;
        #1;
        model_reset();
        checks++;
        if ({instret, wb_valid, RegWrite, C} !== {64'd0, 1'b0, 1'b0, 32'd0})
            $display("FAIL async reset: got instret=%0d valid=%b we=%b C=%h expected all zero", instret, wb_valid, RegWrite, C);
        else passed++;
        idle();
        @(negedge clk);
        rst = 0;
        tick();
    endtask

    task automatic test_random();
        logic [2:0] f3_pool[8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        for (int k = 0; k < 400; k++) begin
            drv($urandom_range(0, 3) != 0, 5'($urandom), $urandom_range(0, 4) != 0, 2'($urandom),
                $urandom, $urandom, $urandom, $urandom, f3_pool[$urandom_range(0, 7) == 7 ? $urandom_range(5, 7) : $urandom_range(0, 4)]);
            stall = $urandom_range(0, 4) == 0;
            flush = $urandom_range(0, 9) == 0;
            tick();
            checks++;
            if ({rd, RegWrite, C, wb_valid, load_fault, instret} !==
                {m_valid ? m_rd : 5'd0, exp_we(), exp_c(), m_valid, exp_fault(), exp_instret})
                $display("FAIL random %0d: got rd=%0d we=%b C=%h v=%b lf=%b n=%0d expected rd=%0d we=%b C=%h v=%b lf=%b n=%0d",
                         k, rd, RegWrite, C, wb_valid, load_fault, instret,
                         m_valid ? m_rd : 5'd0, exp_we(), exp_c(), m_valid, exp_fault(), exp_instret);
            else passed++;
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_fault();
        test_rd0();
        test_stall_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- MEM/WB pipeline stage of the RV32I core; the write-side driver of the register bank.
- Latches the memory-stage bundle and selects the result source (ALU, load, PC+4 or immediate).
- Aligns and extends load data, then drives rd/RegWrite/C into the register bank.
- Also supplies forwarding data, a load-fault flag and a 64-bit retired-instruction counter.

Parameters:
- XLEN, 32, datapath width (fixed at 32 for RV32I).
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  memory stage presents an instruction.
- in_rd  in  5  destination register index.
- in_reg_write  in  1  instruction writes rd.
- in_wb_sel  in  2  result source: 00 ALU, 01 load, 10 PC+4, 11 immediate (LUI).
- in_alu_result  in  32  ALU result; for loads, the effective address.
- in_mem_rdata  in  32  raw word read from data memory (word-aligned).
- in_pc_plus4  in  32  link value for JAL/JALR.
- in_imm  in  32  U-type immediate.
- in_funct3  in  3  load width/sign code.
- stall  in  1  hold the stage register.
- flush  in  1  replace the captured instruction with a bubble.
- rd  out  5  register bank write index.
- RegWrite  out  1  register bank write enable.
- C  out  32  register bank write data; also the forwarding data.
- wb_valid  out  1  stage holds a valid instruction.
- load_fault  out  1  misaligned or illegal load in the stage.
- instret  out  CNT_W  count of retired instructions.

Behaviour:
- Stage register fields: valid, rd, reg_write, wb_sel, alu_result, mem_rdata, pc_plus4, imm, funct3.
- Reset: all stage fields 0, instret 0. Outputs at reset: rd 0, RegWrite 0, C 0, wb_valid 0, load_fault 0.
- Update priority on each rising edge:
  - flush: valid <- 0, other fields don't-care. Flush wins over stall.
  - stall (no flush): all fields hold.
  - neither: all fields capture the in_* inputs.
- Latency: one cycle from an input bundle to the RegWrite/C presentation.
- Outputs are combinational from the stage register only; no input-to-output combinational path.
- Load byte offset = alu_result[1:0].
- Load funct3 decoding:
  - 000 LB: byte at offset*8, sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: half at offset[1]*16, sign-extended.
  - 101 LHU: same half, zero-extended.
  - 010 LW: full word.
- load_fault = valid & wb_sel==01 & (funct3 in {011,110,111} | (LH/LHU & offset[0]) | (LW & offset!=0)).
- C: selected source per wb_sel; forced to 0 when load_fault=1 or valid=0.
- RegWrite = valid & reg_write & (rd!=0) & !load_fault. rd output equals the stage rd whenever valid=1, else 0.
- wb_valid = valid.
- instret increments by 1 on an edge where valid & !load_fault & !stall.
  - A stalled instruction counts once, on the edge it leaves.
  - RegWrite stays asserted through a stall; re-writing the same value is harmless.
  - instret wraps from 2^64-1 to 0.
- flush does not cancel the instruction already held: if it is valid and not stalled, it retires on the flush edge.
- Reset mid-operation: immediate clear; a pending write is dropped; instret returns to 0.

Test Plan:
- Reset released, no input -> RegWrite 0, C 0, instret 0 for 5 cycles.
- ALU: in_valid=1, rd=5, wb_sel=00, alu_result=0x1234_5678 -> next cycle RegWrite=1, rd=5, C=0x12345678; instret=1 one edge later.
- Loads with mem_rdata=0x80FF_7F01:
  - LB off=2 -> C=0xFFFFFFFF.
  - LBU off=3 -> C=0x00000080.
  - LH off=2 -> C=0xFFFF80FF.
  - LHU off=0 -> C=0x00007F01.
  - LW off=0 -> C=0x80FF7F01.
- LW off=2, rd=7 -> load_fault=1, RegWrite=0, C=0, instret unchanged; funct3=011 produces the same response.
- rd=0 with in_reg_write=1, wb_sel=10, pc_plus4=0x104 -> RegWrite=0, instret increments.
- stall for 3 cycles on a valid ALU op -> RegWrite held 3 cycles, instret +1 only once; flush while stalled -> wb_valid=0 next cycle; async rst mid-stream clears instret to 0 without waiting for clk.
